// File: rtl/chimera_pkg.sv
// Shared types and defaults for the cluster isolation/power sequencer.
// Holds the per-cluster state encoding and the state-to-output decode.
package chimera_pkg;

   localparam int unsigned CluIsoTimeoutCycles = 1024;
   localparam int unsigned CluClkSettleCycles  = 4;
   localparam int unsigned CluRstHoldCycles    = 8;

   typedef enum logic [2:0] {
      CLU_ACTIVE = 3'd0,
      CLU_ISO    = 3'd1,
      CLU_GATE   = 3'd2,
      CLU_OFF    = 3'd3,
      CLU_UNGATE = 3'd4,
      CLU_DEISO  = 3'd5
   } clu_iso_state_e;

   typedef struct packed {
      logic isolate;
      logic clk_en;
      logic clu_rst;
      logic busy;
      logic off;
   } clu_iso_out_t;

   function automatic clu_iso_out_t clu_iso_decode(input clu_iso_state_e s);
      clu_iso_out_t o;
      o = '0;
      case (s)
         CLU_ACTIVE: o = '{isolate: 1'b0, clk_en: 1'b1, clu_rst: 1'b0, busy: 1'b0, off: 1'b0};
         CLU_ISO:    o = '{isolate: 1'b1, clk_en: 1'b1, clu_rst: 1'b0, busy: 1'b1, off: 1'b0};
         CLU_GATE:   o = '{isolate: 1'b1, clk_en: 1'b0, clu_rst: 1'b1, busy: 1'b1, off: 1'b0};
         CLU_OFF:    o = '{isolate: 1'b1, clk_en: 1'b0, clu_rst: 1'b1, busy: 1'b0, off: 1'b1};
         CLU_UNGATE: o = '{isolate: 1'b1, clk_en: 1'b1, clu_rst: 1'b1, busy: 1'b1, off: 1'b0};
         CLU_DEISO:  o = '{isolate: 1'b0, clk_en: 1'b1, clu_rst: 1'b0, busy: 1'b1, off: 1'b0};
         default:    o = '0;
      endcase
      return o;
   endfunction

   function automatic int unsigned clu_max3(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/chimera_clu_iso_ctrl_if.sv
// Per-cluster request, handshake and status bundle between the SoC side and the sequencer.
interface chimera_clu_iso_ctrl_if #(
   parameter int unsigned NumClusters = 5
) ();
   logic [NumClusters-1:0] pd_req_i;
   logic [NumClusters-1:0] pu_req_i;
   logic [NumClusters-1:0] err_clr_i;
   logic [NumClusters-1:0] isolated_i;
   logic [NumClusters-1:0] isolate_o;
   logic [NumClusters-1:0] clk_en_o;
   logic [NumClusters-1:0] clu_rst_o;
   logic [NumClusters-1:0] busy_o;
   logic [NumClusters-1:0] off_o;
   logic [NumClusters-1:0] err_o;

   modport master (
      output pd_req_i, pu_req_i, err_clr_i, isolated_i,
      input  isolate_o, clk_en_o, clu_rst_o, busy_o, off_o, err_o
   );

   modport slave (
      input  pd_req_i, pu_req_i, err_clr_i, isolated_i,
      output isolate_o, clk_en_o, clu_rst_o, busy_o, off_o, err_o
   );
endinterface

// File: rtl/chimera_clu_iso_fsm.sv
// Single-cluster isolation/power sequencer: FSM, shared step counter and sticky timeout flag.
// state   | meaning
// ACTIVE  | running, isolation released
// ISO     | isolate raised, waiting for isolated ack
// GATE    | clock gated, reset asserted, settling
// OFF     | fully powered down
// UNGATE  | clock running, reset held
// DEISO   | isolate released, waiting for ack to drop
module chimera_clu_iso_fsm
   import chimera_pkg::*;
#(
   parameter int unsigned TimeoutCycles   = CluIsoTimeoutCycles,
   parameter int unsigned ClkSettleCycles = CluClkSettleCycles,
   parameter int unsigned RstHoldCycles   = CluRstHoldCycles,
   parameter bit          BootOn          = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pd_req_i,
   input  logic pu_req_i,
   input  logic err_clr_i,
   input  logic isolated_i,
   output logic isolate_o,
   output logic clk_en_o,
   output logic clu_rst_o,
   output logic busy_o,
   output logic off_o,
   output logic err_o
);

   localparam int unsigned CntMax = clu_max3(TimeoutCycles, ClkSettleCycles, RstHoldCycles);
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
   localparam logic [CntW-1:0] SettleLast  = CntW'(ClkSettleCycles - 1);
   localparam logic [CntW-1:0] HoldLast    = CntW'(RstHoldCycles - 1);
   localparam clu_iso_state_e  BootState   = BootOn ? CLU_ACTIVE : CLU_OFF;

   if (TimeoutCycles == 0 || ClkSettleCycles == 0 || RstHoldCycles == 0) begin : g_param_check
      $error("chimera_clu_iso_fsm: cycle parameters must all be at least 1");
   end

   clu_iso_state_e  state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            err_q, err_d, err_set;
   clu_iso_out_t    out_q, out_d;

   assign cnt_inc = cnt_q + CntW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_set = 1'b0;
      unique case (state_q)
         CLU_ACTIVE: begin
            if (pd_req_i && !pu_req_i) begin
               state_d = CLU_ISO;
               cnt_d   = '0;
            end
         end
         CLU_ISO: begin
            if (isolated_i) begin
               state_d = CLU_GATE;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               // No ack: back out through DEISO so the cluster is never left half-isolated.
               state_d = CLU_DEISO;
               cnt_d   = '0;
               err_set = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         CLU_GATE: begin
            if (cnt_q == SettleLast) begin
               state_d = CLU_OFF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         CLU_OFF: begin
            if (pu_req_i && !pd_req_i) begin
               state_d = CLU_UNGATE;
               cnt_d   = '0;
            end
         end
         CLU_UNGATE: begin
            if (cnt_q == HoldLast) begin
               state_d = CLU_DEISO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         CLU_DEISO: begin
            if (!isolated_i) begin
               state_d = CLU_ACTIVE;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d = CLU_ACTIVE;
               cnt_d   = '0;
               err_set = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = BootState;
            cnt_d   = '0;
         end
      endcase
      err_d = err_set | (err_q & ~err_clr_i);
      out_d = clu_iso_decode(state_d);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= BootState;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         out_q   <= clu_iso_decode(BootState);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         out_q   <= out_d;
      end
   end

   assign isolate_o = out_q.isolate;
   assign clk_en_o  = out_q.clk_en;
   assign clu_rst_o = out_q.clu_rst;
   assign busy_o    = out_q.busy;
   assign off_o     = out_q.off;
   assign err_o     = err_q;

endmodule

// File: rtl/chimera_clu_iso_ctrl.sv
// Isolation/power sequencer for NumClusters independent clusters, one FSM per cluster.
module chimera_clu_iso_ctrl
   import chimera_pkg::*;
#(
   parameter int unsigned            NumClusters     = 5,
   parameter int unsigned            TimeoutCycles   = CluIsoTimeoutCycles,
   parameter int unsigned            ClkSettleCycles = CluClkSettleCycles,
   parameter int unsigned            RstHoldCycles   = CluRstHoldCycles,
   parameter logic [NumClusters-1:0] BootOn          = '1
) (
   input  logic                 soc_clk_i,
   input  logic                 rst_i,
   chimera_clu_iso_ctrl_if.slave bus
);

   logic [NumClusters-1:0] isolate_w, clk_en_w, clu_rst_w, busy_w, off_w, err_w;

   for (genvar i = 0; i < NumClusters; i++) begin : g_clu
      chimera_clu_iso_fsm #(
         .TimeoutCycles  (TimeoutCycles),
         .ClkSettleCycles(ClkSettleCycles),
         .RstHoldCycles  (RstHoldCycles),
         .BootOn         (BootOn[i])
      ) u_fsm (
         .clk_i     (soc_clk_i),
         .rst_i     (rst_i),
         .pd_req_i  (bus.pd_req_i[i]),
         .pu_req_i  (bus.pu_req_i[i]),
         .err_clr_i (bus.err_clr_i[i]),
         .isolated_i(bus.isolated_i[i]),
         .isolate_o (isolate_w[i]),
         .clk_en_o  (clk_en_w[i]),
         .clu_rst_o (clu_rst_w[i]),
         .busy_o    (busy_w[i]),
         .off_o     (off_w[i]),
         .err_o     (err_w[i])
      );
   end

   assign bus.isolate_o = isolate_w;
   assign bus.clk_en_o  = clk_en_w;
   assign bus.clu_rst_o = clu_rst_w;
   assign bus.busy_o    = busy_w;
   assign bus.off_o     = off_w;
   assign bus.err_o     = err_w;

endmodule

// File: tb/tb_chimera_clu_iso_ctrl.sv
// Scoreboard bench for chimera_clu_iso_ctrl: directed sequences plus randomized traffic
// against a phase/remaining-time reference model.
module tb_chimera_clu_iso_ctrl;

   localparam int N = 2;
   localparam int T = 16;
   localparam int S = 4;
   localparam int R = 8;
   localparam logic [N-1:0] BOOT = 2'b01;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   chimera_clu_iso_ctrl_if #(.NumClusters(N)) bus ();

   chimera_clu_iso_ctrl #(
      .NumClusters    (N),
      .TimeoutCycles  (T),
      .ClkSettleCycles(S),
      .RstHoldCycles  (R),
      .BootOn         (BOOT)
   ) dut (
      .soc_clk_i(clk),
      .rst_i    (rst),
      .bus      (bus)
   );

   typedef enum int {P_ON, P_ISOW, P_SETTLE, P_DOWN, P_HOLD, P_RELW} phase_t;

   typedef struct {
      int             cyc;
      logic [N-1:0]   iso, clk_en, crst, busy, off, err;
   } exp_t;

   phase_t     ph   [N];
   int         left [N];
   bit         merr [N];
   int         mode [N];   // 0: ack follows isolate_o after dly, 1: stuck 0, 2: stuck 1
   int         dly  [N];
   logic [7:0] sh   [N];
   exp_t       q[$];

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] pd, input logic [N-1:0] pu,
                       input logic [N-1:0] clr);
      exp_t         e;
      bit [N-1:0]   iso;
      bit           set;
      phase_t       p;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         sh[i] = {sh[i][6:0], bus.isolate_o[i]};
         iso[i] = (mode[i] == 1) ? 1'b0 : (mode[i] == 2) ? 1'b1 : sh[i][dly[i]];
      end
      rst            = r;
      bus.pd_req_i   = pd;
      bus.pu_req_i   = pu;
      bus.err_clr_i  = clr;
      bus.isolated_i = iso;
      e.cyc = cyc + 1;
      for (int i = 0; i < N; i++) begin
         set = 1'b0;
         if (r) begin
            ph[i]   = BOOT[i] ? P_ON : P_DOWN;
            merr[i] = 1'b0;
         end else begin
            case (ph[i])
               P_ON:     if (pd[i] && !pu[i]) begin ph[i] = P_ISOW; left[i] = T; end
               P_ISOW:   if (iso[i]) begin ph[i] = P_SETTLE; left[i] = S; end
                         else begin
                            left[i]--;
                            if (left[i] == 0) begin ph[i] = P_RELW; left[i] = T; set = 1'b1; end
                         end
               P_SETTLE: begin left[i]--; if (left[i] == 0) ph[i] = P_DOWN; end
               P_DOWN:   if (pu[i] && !pd[i]) begin ph[i] = P_HOLD; left[i] = R; end
               P_HOLD:   begin
                            left[i]--;
                            if (left[i] == 0) begin ph[i] = P_RELW; left[i] = T; end
                         end
               P_RELW:   if (!iso[i]) ph[i] = P_ON;
                         else begin
                            left[i]--;
                            if (left[i] == 0) begin ph[i] = P_ON; set = 1'b1; end
                         end
               default:  ph[i] = P_ON;
            endcase
            if (set) merr[i] = 1'b1;
            else if (clr[i]) merr[i] = 1'b0;
         end
         p = ph[i];
         e.iso[i]    = (p == P_ISOW) || (p == P_SETTLE) || (p == P_DOWN) || (p == P_HOLD);
         e.clk_en[i] = (p == P_ON) || (p == P_ISOW) || (p == P_HOLD) || (p == P_RELW);
         e.crst[i]   = (p == P_SETTLE) || (p == P_DOWN) || (p == P_HOLD);
         e.busy[i]   = (p == P_ISOW) || (p == P_SETTLE) || (p == P_HOLD) || (p == P_RELW);
         e.off[i]    = (p == P_DOWN);
         e.err[i]    = merr[i];
      end
      q.push_back(e);
   endtask

   // Monitor: compares every cycle's outputs against the entry predicted for that cycle.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         n_chk++;
         if ({bus.isolate_o, bus.clk_en_o, bus.clu_rst_o, bus.busy_o, bus.off_o, bus.err_o} !==
             {e.iso, e.clk_en, e.crst, e.busy, e.off, e.err}) begin
            n_fail++;
            $display("FAIL outputs cyc %0d: got iso=%b clk_en=%b rst=%b busy=%b off=%b err=%b, required iso=%b clk_en=%b rst=%b busy=%b off=%b err=%b",
                     cyc, bus.isolate_o, bus.clk_en_o, bus.clu_rst_o, bus.busy_o, bus.off_o,
                     bus.err_o, e.iso, e.clk_en, e.crst, e.busy, e.off, e.err);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, t_a, t_b, t_c, t_d, err_after, toggles;
      logic [N-1:0] pd, pu, clr;
      logic r;
      logic [1:0] snap;

      rst = 1'b1;
      bus.pd_req_i = '0; bus.pu_req_i = '0; bus.err_clr_i = '0; bus.isolated_i = '0;
      for (int i = 0; i < N; i++) begin
         mode[i] = 0; dly[i] = 0; sh[i] = '0; ph[i] = P_ON; left[i] = 0; merr[i] = 1'b0;
      end

      repeat (10) step(1'b1, '0, '0, '0);
      step(1'b0, '0, '0, '0);
      chk("reset isolate_o", int'(bus.isolate_o), 2);
      chk("reset clk_en_o",  int'(bus.clk_en_o),  1);
      chk("reset clu_rst_o", int'(bus.clu_rst_o), 2);
      chk("reset off_o",     int'(bus.off_o),     2);
      chk("reset busy_o",    int'(bus.busy_o),    0);
      chk("reset err_o",     int'(bus.err_o),     0);

      // Power-down of cluster 0 with a 3-cycle ack delay.
      dly[0] = 3;
      step(1'b0, 2'b01, '0, '0);
      c0 = cyc; t_a = -1; t_b = -1; t_c = -1; err_after = 0;
      for (int k = 0; k < 40; k++) begin
         step(1'b0, '0, '0, '0);
         if (t_a < 0 && bus.isolate_o[0]) t_a = cyc - c0;
         if (t_b < 0 && !bus.clk_en_o[0]) t_b = cyc - c0;
         if (t_c < 0 && bus.off_o[0])     t_c = cyc - c0;
         if (bus.err_o[0]) err_after = 1;
      end
      chk("pd isolate rise cycle", t_a, 1);
      chk("pd clk_en fall cycle",  t_b, 2 + dly[0]);
      chk("pd off rise cycle",     t_c, 2 + dly[0] + S);
      chk("pd err stays low",      err_after, 0);

      // Power-up of cluster 1 (boot OFF) with a 2-cycle ack delay.
      dly[1] = 2;
      step(1'b0, '0, 2'b10, '0);
      c0 = cyc; t_a = -1; t_b = -1; t_c = -1; t_d = -1;
      for (int k = 0; k < 40; k++) begin
         step(1'b0, '0, '0, '0);
         if (t_a < 0 && bus.clk_en_o[1])   t_a = cyc - c0;
         if (t_b < 0 && !bus.clu_rst_o[1]) t_b = cyc - c0;
         if (t_c < 0 && !bus.isolate_o[1]) t_c = cyc - c0;
         if (t_d < 0 && !bus.busy_o[1] && !bus.off_o[1]) t_d = cyc - c0;
      end
      chk("pu clk_en rise cycle",  t_a, 1);
      chk("pu clu_rst fall cycle", t_b, R + 1);
      chk("pu isolate fall cycle", t_c, R + 1);
      chk("pu active cycle",       t_d, R + 2 + dly[1]);

      // Bring cluster 0 back, then time out with ack stuck low while err_clr is held.
      dly[0] = 0;
      step(1'b0, '0, 2'b01, '0);
      repeat (20) step(1'b0, '0, '0, '0);
      mode[0] = 1;
      step(1'b0, 2'b01, '0, 2'b01);
      c0 = cyc; t_a = -1; t_b = -1; err_after = -1;
      for (int k = 0; k < 40; k++) begin
         step(1'b0, '0, '0, 2'b01);
         if (t_a >= 0 && err_after < 0) err_after = int'(bus.err_o[0]);
         if (t_a < 0 && bus.err_o[0]) begin
            t_a = cyc - c0;
            t_b = int'(bus.busy_o[0] && !bus.isolate_o[0] && bus.clk_en_o[0]);
         end
      end
      chk("timeout err rise cycle",  t_a, T + 1);
      chk("timeout lands in DEISO",  t_b, 1);
      chk("err_clr clears next cyc", err_after, 0);

      // Ignored requests in ACTIVE: pu alone and pd+pu together.
      mode[0] = 0;
      snap = {bus.isolate_o[0], bus.clk_en_o[0]};
      toggles = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, (k % 2) ? 2'b01 : 2'b00, 2'b01, '0);
         if ({bus.isolate_o[0], bus.clk_en_o[0]} !== snap) toggles++;
      end
      chk("ignored requests toggles", toggles, 0);

      // Reset asserted while cluster 0 is in GATE.
      dly[0] = 1;
      step(1'b0, 2'b01, '0, '0);
      t_a = -1;
      for (int k = 0; k < 20 && t_a < 0; k++) begin
         step(1'b0, '0, '0, '0);
         if (!bus.clk_en_o[0]) t_a = k;
      end
      chk("gate reached before reset", int'(t_a >= 0), 1);
      step(1'b1, '0, '0, '0);
      step(1'b0, '0, '0, '0);
      chk("mid reset clk_en_o[0]", int'(bus.clk_en_o[0]), 1);
      chk("mid reset isolate_o[0]", int'(bus.isolate_o[0]), 0);
      chk("mid reset err_o", int'(bus.err_o), 0);

      // Randomized traffic on both clusters.
      for (int k = 0; k < 3000; k++) begin
         if (k % 50 == 0) begin
            for (int i = 0; i < N; i++) begin
               int m;
               m = $urandom_range(0, 19);
               mode[i] = (m < 14) ? 0 : (m < 17) ? 1 : 2;
               dly[i]  = $urandom_range(0, 5);
            end
         end
         for (int i = 0; i < N; i++) begin
            pd[i]  = ($urandom_range(0, 5) == 0);
            pu[i]  = ($urandom_range(0, 5) == 0);
            clr[i] = ($urandom_range(0, 7) == 0);
         end
         r = ($urandom_range(0, 299) == 0);
         step(r, pd, pu, clr);
      end
      repeat (2) step(1'b0, '0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/chimera_clu_iso_ctrl.md
Name: chimera_clu_iso_ctrl

Overview:
Per-cluster isolation/power sequencer that drives the cluster domain's isolation handshake from the controlling side. It raises isolate requests toward each cluster's AXI isolation layer, waits for the cluster's isolated acknowledge, then gates the cluster clock and asserts the cluster reset. It runs the reverse sequence on power-up. It sits in the SoC clock domain between the software-visible control registers and the cluster domain's isolate/isolated, clock-enable and reset-sync inputs.

Parameters:
NumClusters, 5, number of external clusters sequenced, one independent FSM each
TimeoutCycles, 1024, cycles allowed for isolated_i to reach the requested level
ClkSettleCycles, 4, cycles with clock gated before OFF is reported
RstHoldCycles, 8, cycles reset is held with clock running on power-up
BootOn, '1 (NumClusters bits), per-cluster state after reset: 1 means ACTIVE, 0 means OFF

Ports:
soc_clk_i  in  1  SoC clock; the only clock
rst_i  in  1  synchronous, active-high reset
pd_req_i  in  NumClusters  power-down request pulse, one per cluster
pu_req_i  in  NumClusters  power-up request pulse, one per cluster
err_clr_i  in  NumClusters  clears the sticky err_o bit
isolated_i  in  NumClusters  isolation acknowledge from the cluster domain
isolate_o  out  NumClusters  isolation request to the cluster domain
clk_en_o  out  NumClusters  cluster clock enable, 1 means running
clu_rst_o  out  NumClusters  cluster reset request, active-high
busy_o  out  NumClusters  FSM is in a transitional state
off_o  out  NumClusters  cluster is fully OFF
err_o  out  NumClusters  sticky handshake-timeout flag

Behaviour:
- One FSM per cluster; the FSMs are fully independent. All outputs are decoded from registered state (Moore), so a request takes effect on outputs 1 cycle later.
- States and outputs (isolate/clk_en/clu_rst):
  - ACTIVE: 0/1/0
  - ISO: 1/1/0
  - GATE: 1/0/1
  - OFF: 1/0/1
  - UNGATE: 1/1/1
  - DEISO: 0/1/0
- busy_o=1 in ISO, GATE, UNGATE, DEISO. off_o=1 only in OFF.
- Reset (rst_i=1, synchronous): state is ACTIVE if BootOn[i], else OFF. Counter is cleared and err_o=0. Outputs follow the state table. Reset mid-sequence aborts immediately to the boot state.
- Transitions:
  - ACTIVE + pd_req -> ISO, counter cleared.
  - ISO: if isolated_i=1 -> GATE, counter cleared. Else the counter increments. When counter==TimeoutCycles-1 without ack -> DEISO with err set (abort, isolation released).
  - GATE: counter increments. At ClkSettleCycles-1 -> OFF.
  - OFF + pu_req -> UNGATE, counter cleared.
  - UNGATE: counter increments. At RstHoldCycles-1 -> DEISO, counter cleared.
  - DEISO: if isolated_i=0 -> ACTIVE. Else the counter increments. At TimeoutCycles-1 -> ACTIVE with err set.
- Requests are pulses and are not queued. pd_req outside ACTIVE and pu_req outside OFF are ignored. pd_req and pu_req asserted together in the same cycle are both ignored.
- isolated_i is sampled only in ISO and DEISO. Its value is don't-care in every other state.
- err_o is set on any timeout and held until err_clr_i. If set and clear coincide, set wins.
- Counter width is $clog2(max(TimeoutCycles, ClkSettleCycles, RstHoldCycles)+1). The counter never wraps, because every terminal count forces a state change. Each of the three cycle parameters must be ≥1; this is checked by an elaboration assertion.
- Minimum power-down latency (pd_req to off_o): 2 + ClkSettleCycles cycles when isolated_i acks immediately.

Decomposition:
- chimera_pkg holds:
  - clu_iso_state_e (enum, 3 bits)
  - default constants: CluIsoTimeoutCycles, CluClkSettleCycles, CluRstHoldCycles
- Sub-module chimera_clu_iso_fsm: a single-cluster FSM, counter and err bit. The top generates NumClusters instances of it.

Test Plan:
- Reset with BootOn=2'b01, NumClusters=2: cluster0 outputs isolate=0, clk_en=1, rst=0; cluster1 outputs isolate=1, clk_en=0, rst=1, off_o=1; err_o=0.
- Power-down, ClkSettleCycles=4: pd_req[0] pulse at cycle 0, isolated_i[0] tied to isolate_o[0] with a 3-cycle delay. Required: isolate_o rises at cycle 1, clk_en_o falls at cycle 5, off_o rises at cycle 9, err_o stays 0.
- Power-up, RstHoldCycles=8, from OFF: pu_req pulse at cycle 0. Required: clk_en_o=1 at cycle 1, clu_rst_o falls at cycle 9, isolate_o falls at cycle 9. When isolated_i drops at cycle 11, the FSM is ACTIVE at cycle 12 with busy_o=0.
- Isolation timeout, TimeoutCycles=16, isolated_i stuck at 0: after pd_req, the FSM reaches DEISO at cycle 17 with err_o=1, then ACTIVE. err_clr_i pulse clears err_o the next cycle. err_clr_i asserted on the same cycle as a set leaves err_o=1.
- Ignored requests: pd_req while in ISO, pu_req while ACTIVE, and simultaneous pd_req+pu_req in ACTIVE all cause no state change and no output toggle for 20 cycles.
- Reset mid-sequence: rst_i asserted during GATE. The next cycle shows boot-state outputs and err_o=0. Cluster 1 sequencing runs concurrently and is unaffected by cluster 0 activity.
